// File: rtl/ucaspian_pkt_pkg.sv
// Shared packet framing definitions for the uCaspian host link (tx framer, future rx deframer).
package ucaspian_pkt_pkg;

   localparam logic [7:0] PKT_SYNC = 8'hA5;

   typedef enum logic [2:0] {
      FILL    = 3'd0,
      HDR     = 3'd1,
      LEN     = 3'd2,
      PAYLOAD = 3'd3,
      CSUM    = 3'd4
   } tx_state_t;

   typedef logic [7:0] pkt_len_t;

   // Trailer byte covers the length byte as well as every payload byte.
   function automatic logic [7:0] pkt_trailer(input logic [7:0] payload_xor, input pkt_len_t len);
      return payload_xor ^ len;
   endfunction

endpackage

// File: rtl/tx_pkt_framer_if.sv
// Byte-wide valid/ready stream used on both sides of the packet framer.
interface tx_pkt_framer_if;

   logic [7:0] tdata;
   logic       tvalid;
   logic       tready;

   modport master (output tdata, output tvalid, input tready);
   modport slave  (input tdata, input tvalid, output tready);

endinterface

// File: rtl/pkt_buf_ram.sv
// Single-port payload buffer with synchronous write and registered read.
module pkt_buf_ram #(
   parameter int unsigned DEPTH = 64,
   parameter int unsigned AW    = 6
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [7:0]    wdata,
   output logic [7:0]    rdata
);

   logic [7:0] mem [DEPTH];
   logic [7:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      rdata_q <= mem[addr];
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/tx_pkt_framer.sv
// Buffers outgoing core bytes and emits them as SYNC/LEN/payload/XOR-checksum packets.
module tx_pkt_framer
   import ucaspian_pkt_pkg::*;
#(
   parameter int unsigned MAX_LEN = 64,
   parameter int unsigned TIMEOUT = 1024,
   parameter logic [7:0]  SYNC    = PKT_SYNC
) (
   input  logic clk,
   input  logic rst,
   tx_pkt_framer_if.slave  s_axis,
   tx_pkt_framer_if.master m_axis,
   input  logic flush,
   output logic busy
);

   localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int unsigned IW = $clog2(TIMEOUT + 1);

   localparam logic [2:0] S_FILL    = 3'(FILL);
   localparam logic [2:0] S_HDR     = 3'(HDR);
   localparam logic [2:0] S_LEN     = 3'(LEN);
   localparam logic [2:0] S_PAYLOAD = 3'(PAYLOAD);
   localparam logic [2:0] S_CSUM    = 3'(CSUM);

   logic [2:0]    state_q,    state_d;
   pkt_len_t      count_q,    count_d;
   logic [7:0]    csum_q,     csum_d;
   logic [IW-1:0] idle_q,     idle_d;
   pkt_len_t      ptr_q,      ptr_d;
   logic [7:0]    m_tdata_q,  m_tdata_d;
   logic          m_tvalid_q, m_tvalid_d;
   logic          s_tready_q, s_tready_d;
   logic          busy_q,     busy_d;

   logic          accept;
   logic          m_hs;
   logic          trigger;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [7:0]    ram_rdata;

   assign accept = s_tready_q & s_axis.tvalid;
   assign m_hs   = m_tvalid_q & m_axis.tready;

   // Next state, buffer bookkeeping and the registered output beat.
   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      csum_d     = csum_q;
      idle_d     = idle_q;
      ptr_d      = ptr_q;
      m_tdata_d  = m_tdata_q;
      m_tvalid_d = m_tvalid_q;
      ram_we     = 1'b0;
      trigger    = 1'b0;

      case (state_q)
         S_FILL: begin
            if (accept) begin
               ram_we  = 1'b1;
               count_d = count_q + 8'd1;
               csum_d  = csum_q ^ s_axis.tdata;
               idle_d  = '0;
            end else if ((count_q != 8'd0) && (idle_q != IW'(TIMEOUT))) begin
               idle_d = idle_q + IW'(1);
            end
            trigger = (count_d == 8'(MAX_LEN))
                    | ((idle_q == IW'(TIMEOUT)) & (count_q != 8'd0))
                    | (flush & (count_d != 8'd0));
            if (trigger) begin
               state_d    = S_HDR;
               m_tvalid_d = 1'b1;
               m_tdata_d  = SYNC;
               ptr_d      = 8'd0;
            end
         end

         S_HDR: begin
            if (m_hs) begin
               state_d   = S_LEN;
               m_tdata_d = count_q;
            end
         end

         S_LEN: begin
            if (m_hs) begin
               state_d   = S_PAYLOAD;
               m_tdata_d = ram_rdata;
               ptr_d     = 8'd1;
            end
         end

         S_PAYLOAD: begin
            if (m_hs) begin
               if (ptr_q == count_q) begin
                  state_d   = S_CSUM;
                  m_tdata_d = pkt_trailer(csum_q, count_q);
               end else begin
                  m_tdata_d = ram_rdata;
                  ptr_d     = ptr_q + 8'd1;
               end
            end
         end

         S_CSUM: begin
            if (m_hs) begin
               state_d    = S_FILL;
               m_tvalid_d = 1'b0;
               m_tdata_d  = 8'h00;
               count_d    = 8'd0;
               csum_d     = 8'h00;
               idle_d     = '0;
               ptr_d      = 8'd0;
            end
         end

         default: begin
            state_d    = S_FILL;
            m_tvalid_d = 1'b0;
            m_tdata_d  = 8'h00;
            count_d    = 8'd0;
            csum_d     = 8'h00;
            idle_d     = '0;
            ptr_d      = 8'd0;
         end
      endcase

      s_tready_d = (state_d == S_FILL);
      busy_d     = (state_d != S_FILL);
   end

   // Writes use the fill position; emission reads the byte needed after the next handshake.
   always_comb begin
      if (state_q == S_FILL) begin
         ram_addr = AW'(count_q);
      end else if (ptr_d < count_q) begin
         ram_addr = AW'(ptr_d);
      end else begin
         ram_addr = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_FILL;
         count_q    <= 8'd0;
         csum_q     <= 8'h00;
         idle_q     <= '0;
         ptr_q      <= 8'd0;
         m_tdata_q  <= 8'h00;
         m_tvalid_q <= 1'b0;
         s_tready_q <= 1'b1;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         csum_q     <= csum_d;
         idle_q     <= idle_d;
         ptr_q      <= ptr_d;
         m_tdata_q  <= m_tdata_d;
         m_tvalid_q <= m_tvalid_d;
         s_tready_q <= s_tready_d;
         busy_q     <= busy_d;
      end
   end

   pkt_buf_ram #(
      .DEPTH (MAX_LEN),
      .AW    (AW)
   ) u_buf (
      .clk   (clk),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (s_axis.tdata),
      .rdata (ram_rdata)
   );

   // Input is held off during reset regardless of the registered ready flag.
   assign s_axis.tready = s_tready_q & ~rst;
   assign m_axis.tdata  = m_tdata_q;
   assign m_axis.tvalid = m_tvalid_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_tx_pkt_framer.sv
// Directed bench for tx_pkt_framer: packet-level reference model plus literal expected packets.
module tb_tx_pkt_framer;

   localparam int unsigned MAX_LEN = 4;
   localparam int unsigned TIMEOUT = 8;

   logic clk = 1'b0;
   logic rst;
   logic flush;
   logic busy;

   always #5 clk = ~clk;

   tx_pkt_framer_if s_if ();
   tx_pkt_framer_if m_if ();

   tx_pkt_framer #(
      .MAX_LEN (MAX_LEN),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .s_axis (s_if),
      .m_axis (m_if),
      .flush  (flush),
      .busy   (busy)
   );

   int         vectors = 0;
   int         errors  = 0;
   logic [7:0] log_q [$];
   logic [7:0] exp_q [$];
   logic [7:0] pay_q [$];
   logic [7:0] lit   [$];
   int         idle_m = 0;
   int         idle_prev;
   bit         emitting = 1'b0;
   logic [7:0] sum_m;

   bit         bp_en = 1'b0;
   logic [3:0] bp_pat = 4'b1001;
   int         bp_idx = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Downstream ready: constant high, or the 1,0,0,1 pattern under backpressure.
   always @(posedge clk) begin
      #1;
      m_if.tready = bp_en ? bp_pat[bp_idx] : 1'b1;
      bp_idx = (bp_idx + 1) % 4;
   end

   // Packet-level model and per-cycle compare.
   always @(negedge clk) begin
      if (rst) begin
         chk("s_tready_rst", 32'(s_if.tready), 32'd0);
         exp_q.delete();
         pay_q.delete();
         idle_m   = 0;
         emitting = 1'b0;
      end else if (emitting) begin
         chk("s_tready_emit", 32'(s_if.tready), 32'd0);
         chk("busy_emit", 32'(busy), 32'd1);
         chk("m_tvalid_emit", 32'(m_if.tvalid), 32'd1);
         chk("m_tdata", 32'(m_if.tdata), 32'(exp_q[0]));
         if (m_if.tvalid && m_if.tready) begin
            log_q.push_back(m_if.tdata);
            void'(exp_q.pop_front());
            emitting = (exp_q.size() != 0);
         end
      end else begin
         chk("s_tready_fill", 32'(s_if.tready), 32'd1);
         chk("busy_fill", 32'(busy), 32'd0);
         chk("m_tvalid_fill", 32'(m_if.tvalid), 32'd0);
         idle_prev = idle_m;
         if (s_if.tvalid) begin
            pay_q.push_back(s_if.tdata);
            idle_m = 0;
         end else if (pay_q.size() != 0 && idle_m < int'(TIMEOUT)) begin
            idle_m++;
         end
         if (pay_q.size() == int'(MAX_LEN) ||
             (idle_prev == int'(TIMEOUT) && pay_q.size() != 0) ||
             (flush && pay_q.size() != 0)) begin
            sum_m = 8'(pay_q.size());
            exp_q.push_back(8'hA5);
            exp_q.push_back(8'(pay_q.size()));
            foreach (pay_q[i]) begin
               exp_q.push_back(pay_q[i]);
               sum_m = sum_m ^ pay_q[i];
            end
            exp_q.push_back(sum_m);
            pay_q.delete();
            idle_m   = 0;
            emitting = 1'b1;
         end
      end
   end

   task automatic drive(input logic v, input logic [7:0] d, input logic f);
      @(posedge clk);
      #1;
      s_if.tvalid = v;
      s_if.tdata  = d;
      flush       = f;
   endtask

   task automatic send(input logic [7:0] b, input logic f);
      int n;
      n = 0;
      do begin
         drive(1'b1, b, f);
         @(negedge clk);
         n++;
      end while (!s_if.tready && n < 200);
      if (!s_if.tready) begin
         vectors++;
         errors++;
         $display("FAIL send_timeout: byte %0h not accepted, ready %0b, required 1", b, s_if.tready);
      end
   endtask

   task automatic wait_idle(input logic f);
      int n;
      n = 0;
      do begin
         drive(1'b0, 8'h00, f);
         @(negedge clk);
         #1;
         n++;
      end while (emitting && n < 300);
      if (emitting) begin
         vectors++;
         errors++;
         $display("FAIL drain_timeout: packet still pending with %0d bytes, required 0", exp_q.size());
      end
   endtask

   task automatic check_log(input string name);
      chk({name, "_len"}, 32'(log_q.size()), 32'(lit.size()));
      foreach (lit[i]) begin
         if (i < log_q.size()) begin
            chk(name, 32'(log_q[i]), 32'(lit[i]));
         end
      end
      log_q.delete();
   endtask

   initial begin
      int n;
      rst         = 1'b1;
      flush       = 1'b0;
      s_if.tvalid = 1'b0;
      s_if.tdata  = 8'h00;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_m_tvalid", 32'(m_if.tvalid), 32'd0);
      chk("rst_m_tdata", 32'(m_if.tdata), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_s_tready", 32'(s_if.tready), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_s_tready", 32'(s_if.tready), 32'd1);

      // Full packet
      send(8'h10, 1'b0); send(8'h20, 1'b0); send(8'h30, 1'b0); send(8'h40, 1'b0);
      wait_idle(1'b0);
      lit = '{8'hA5, 8'h04, 8'h10, 8'h20, 8'h30, 8'h40, 8'h44};
      check_log("full_pkt");

      // Idle timeout: SYNC appears ten cycles after the last accepted byte
      send(8'hAA, 1'b0); send(8'h55, 1'b0);
      n = 0;
      do begin
         drive(1'b0, 8'h00, 1'b0);
         @(negedge clk);
         n++;
      end while (!m_if.tvalid && n < 50);
      chk("timeout_latency", 32'(n), 32'd10);
      wait_idle(1'b0);
      lit = '{8'hA5, 8'h02, 8'hAA, 8'h55, 8'hFD};
      check_log("timeout_pkt");

      // Flush on empty buffer is ignored, then a one-byte flush
      drive(1'b0, 8'h00, 1'b1);
      repeat (4) drive(1'b0, 8'h00, 1'b0);
      @(negedge clk);
      chk("empty_flush_len", 32'(log_q.size()), 32'd0);
      send(8'h7E, 1'b0);
      drive(1'b0, 8'h00, 1'b1);
      wait_idle(1'b0);
      lit = '{8'hA5, 8'h01, 8'h7E, 8'h7F};
      check_log("flush_pkt");

      // Backpressure, with flush pulses during emission that must be ignored
      bp_en = 1'b1;
      send(8'h10, 1'b0); send(8'h20, 1'b0); send(8'h30, 1'b0); send(8'h40, 1'b0);
      wait_idle(1'b1);
      drive(1'b0, 8'h00, 1'b0);
      bp_en = 1'b0;
      repeat (3) drive(1'b0, 8'h00, 1'b0);
      lit = '{8'hA5, 8'h04, 8'h10, 8'h20, 8'h30, 8'h40, 8'h44};
      check_log("bp_pkt");

      // Reset after three output beats
      send(8'h10, 1'b0); send(8'h20, 1'b0); send(8'h30, 1'b0); send(8'h40, 1'b0);
      repeat (3) drive(1'b0, 8'h00, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_m_tvalid", 32'(m_if.tvalid), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      lit = '{8'hA5, 8'h04, 8'h10};
      check_log("pre_rst_beats");
      send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b0);
      wait_idle(1'b0);
      lit = '{8'hA5, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00};
      check_log("post_rst_pkt");

      // Final byte with flush in the same cycle: one packet, then an empty buffer
      send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b1);
      wait_idle(1'b0);
      repeat (3) drive(1'b0, 8'h00, 1'b1);
      repeat (2) drive(1'b0, 8'h00, 1'b0);
      lit = '{8'hA5, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h40};
      check_log("full_flush_pkt");
      send(8'h55, 1'b0);
      drive(1'b0, 8'h00, 1'b1);
      wait_idle(1'b0);
      lit = '{8'hA5, 8'h01, 8'h55, 8'h54};
      check_log("refill_pkt");

      repeat (3) drive(1'b0, 8'h00, 1'b0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/tx_pkt_framer.md
# tx_pkt_framer

Byte-stream packetiser between the uCaspian core's outgoing byte stream (`write_data`/`write_vld`/`write_rdy`) and the outgoing host FIFO. It buffers core output bytes and emits them as framed packets: sync byte, length, payload, XOR checksum. This lets the host resynchronise and detect corrupted transfers over the FT245 link. A packet is flushed when the buffer fills, when input goes idle for a set time, or on explicit request.

## Interface
- `MAX_LEN`, 64: maximum payload bytes per packet; legal range 1..255.
- `TIMEOUT`, 1024: idle cycles with a non-empty buffer before auto-flush; legal values ≥ 1.
- `SYNC`, 8'hA5: first byte of every packet.

Ports:
- `clk` in 1: system clock. This is the block's only clock.
- `rst` in 1: synchronous, active-high reset.
- `s_axis_tdata` in 8: payload byte from the core.
- `s_axis_tvalid` in 1: payload byte valid.
- `s_axis_tready` out 1: block accepts a payload byte.
- `m_axis_tdata` out 8: framed byte to the outgoing FIFO.
- `m_axis_tvalid` out 1: framed byte valid.
- `m_axis_tready` in 1: downstream accepts the byte.
- `flush` in 1: single-cycle request to close the current packet.
- `busy` out 1: high while a packet is being emitted.

## Operation
- **Reset values:** `s_axis_tready`=0 while `rst` is high; `m_axis_tvalid`=0; `m_axis_tdata`=0; `busy`=0. Internally count=0, csum=0, idle=0, state=FILL.
- **FSM:** FILL → HDR → LEN → PAYLOAD → CSUM → FILL.
- **FILL state:**
  - `s_axis_tready`=1.
  - On each input handshake: write the byte to `buf[count]`, set csum ^= byte, increment count, clear idle.
  - When count>0 and no byte is accepted, increment idle, saturating at TIMEOUT.
- **Leaving FILL:** go to HDR on the cycle after any of these:
  - count reaches MAX_LEN (including via the current beat);
  - idle == TIMEOUT with count>0;
  - `flush` asserted with count>0, where count includes a byte accepted in the same cycle.
- **Empty buffer:** an empty packet is never emitted. `flush` with count==0 is ignored.
- **Emission:**
  - HDR emits SYNC.
  - LEN emits count.
  - PAYLOAD emits `buf[0..count-1]` in order.
  - CSUM emits csum ^ count, i.e. the XOR of the length byte and all payload bytes.
  - Each state advances only on an `m_axis` handshake.
- **After CSUM handshake:** clear count, csum and idle, and return to FILL.
- **Input during emission:** `s_axis_tready`=0 for the whole emission (single buffer). `flush` is ignored during emission and is not latched.
- **Widths:** count is 8 bits; idle is `$clog2(TIMEOUT+1)` bits; the buffer index is `$clog2(MAX_LEN)` bits.
- **Reset mid-operation:** the partial buffer or packet is discarded. No truncated tail is emitted. The next packet starts with SYNC.

## Timing
- **Output register:** `m_axis_tdata`/`m_axis_tvalid` are driven from registers. While tvalid=1 and tready=0, tdata and tvalid hold stable.
- **Trigger latency:** first SYNC beat is valid 1 cycle after the trigger cycle.
- **Buffer read:** synchronous, 1-cycle latency. It is prefetched during HDR/LEN so PAYLOAD beats are back-to-back.
- **Throughput:** with tready held high, an N-byte packet takes N+3 consecutive beats. `s_axis_tready` returns to 1 in the cycle after the CSUM handshake.
- **`busy`:** asserted from the HDR entry cycle through the CSUM handshake cycle.
- **Simultaneous events:**
  - byte accepted + `flush` in the same cycle: the byte is included;
  - count reaches MAX_LEN + `flush` in the same cycle: exactly one packet;
  - idle timeout + `flush` in the same cycle: one packet.

## Structure
- **Package `ucaspian_pkt_pkg`:**
  - `PKT_SYNC` default constant;
  - `tx_state_t` enum {FILL, HDR, LEN, PAYLOAD, CSUM};
  - `pkt_len_t` (8-bit) typedef.
  - Shared with a future rx deframer.
- **Sub-module `pkt_buf_ram`:** single-port, MAX_LEN×8, synchronous write/read. Writes happen only in FILL and reads only during emission, so there are never concurrent accesses. It must infer block or distributed RAM.

## Test plan
Parameters for all scenarios: MAX_LEN=4, TIMEOUT=8.

1. **Full packet:** send 10 20 30 40 with `m_axis_tready`=1 → output A5 04 10 20 30 40 44 on consecutive beats; `s_axis_tready`=0 during those 7 beats.
2. **Idle timeout:** send AA 55, then hold tvalid=0 → after 8 idle cycles, output A5 02 AA 55 FD.
3. **Flush:** `flush` with an empty buffer → no output. Send 7E, then `flush` → A5 01 7E 7F.
4. **Backpressure:** scenario 1 with `m_axis_tready` toggling 1,0,0,1,… → identical byte sequence; tdata stable whenever tvalid&&!tready; no input accepted until after the CSUM handshake.
5. **Reset mid-emission:** `rst` after 3 output beats → `m_axis_tvalid`=0 the next cycle. Then send 01 02 03 04 → A5 04 01 02 03 04 00, with no stale bytes.
6. **Flush with final byte:** 4th byte accepted with `flush` in the same cycle → exactly one 4-byte packet; FILL is re-entered with count=0.
